// File: rtl/smadd_pkg.sv
// Shared definitions for the sign-magnitude add/subtract arbiter slice.
package smadd_pkg;

  // Default word geometry: 32-bit sign-magnitude word, Q16 fraction.
  localparam int N_DEF    = 32;
  localparam int Q_DEF    = 16;
  localparam int NREQ_DEF = 4;

  // The overflow counter saturates here instead of wrapping.
  localparam logic [7:0] OVF_CNT_MAX = 8'd255;

  // Response register occupancy: EMPTY means rsp_valid=0, FULL means rsp_valid=1.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/smadd_core.sv
// Combinational sign-magnitude adder/subtractor with magnitude saturation.
// Subtraction flips the sign of b and reuses the add path. Results of zero
// magnitude are always reported with a positive sign.
module smadd_core
  import smadd_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum,
  output logic         ovf
);

  logic         sign_a;
  logic         sign_b;
  logic [N-2:0] mag_a;
  logic [N-2:0] mag_b;
  logic [N-1:0] mag_total;
  logic [N-2:0] mag_res;
  logic         sign_res;

  // Split operands, pick add or subtract of magnitudes, then saturate and fix zero sign.
  always_comb begin
    sign_a    = a[N-1];
    sign_b    = b[N-1] ^ sub;
    mag_a     = a[N-2:0];
    mag_b     = b[N-2:0];
    mag_total = {1'b0, mag_a} + {1'b0, mag_b};
    mag_res   = '0;
    sign_res  = 1'b0;
    ovf       = 1'b0;

    if (sign_a == sign_b) begin
      // Same effective sign: magnitudes add, a carry out means saturation.
      sign_res = sign_a;
      if (mag_total[N-1]) begin
        ovf     = 1'b1;
        mag_res = '1;
      end else begin
        mag_res = mag_total[N-2:0];
      end
    end else if (mag_a >= mag_b) begin
      // Opposite signs, a dominates.
      mag_res  = mag_a - mag_b;
      sign_res = sign_a;
    end else begin
      // Opposite signs, b dominates.
      mag_res  = mag_b - mag_a;
      sign_res = sign_b;
    end

    // Never emit negative zero.
    if (mag_res == '0) begin
      sign_res = 1'b0;
    end

    sum = {sign_res, mag_res};
  end

endmodule

// File: rtl/smadd_arbiter.sv
// Round-robin arbiter in front of a single sign-magnitude add/sub unit.
// Handshake: a transfer happens on a port in any cycle where its valid and
// ready are both high; req_ready is the one-hot grant and is only raised when
// the operation is actually taken, and rsp_* hold stable while rsp_valid=1
// and rsp_ready=0.
module smadd_arbiter
  import smadd_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int Q    = Q_DEF,
  parameter int NREQ = NREQ_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_sub,
  input  logic [NREQ*N-1:0]        req_a,
  input  logic [NREQ*N-1:0]        req_b,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [N-1:0]             rsp_data,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic                     rsp_ovf,
  output logic [7:0]               ovf_count,
  output state_t                   state_dbg,
  output logic [$clog2(NREQ)-1:0]  ptr_dbg
);

  localparam int IDW = $clog2(NREQ);

  // Reject unsupported geometries at elaboration time.
  if (NREQ < 2 || NREQ > 8 || (NREQ & (NREQ - 1)) != 0 || Q < 0 || Q > N - 1) begin : g_param_check
    $error("smadd_arbiter: NREQ must be a power of two in 2..8 and Q must fit in the magnitude");
  end

  state_t           state;
  state_t           state_nxt;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   gidx;
  logic [IDW-1:0]   scan_idx;
  logic             found;
  logic             accept;
  logic [N-1:0]     op_a;
  logic [N-1:0]     op_b;
  logic             op_sub;
  logic [N-1:0]     core_sum;
  logic             core_ovf;

  assign rsp_valid = (state == FULL);
  assign state_dbg = state;
  assign ptr_dbg   = ptr;

  // Rotating priority search: first valid requester at or after ptr.
  always_comb begin
    found    = 1'b0;
    gidx     = '0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = ptr + IDW'(k);
      if (!found && req_valid[scan_idx]) begin
        found = 1'b1;
        gidx  = scan_idx;
      end
    end
  end

  // Take an operation only when the response slot is free or being drained.
  always_comb begin
    accept = found && !reset && !flush && (!rsp_valid || rsp_ready);
  end

  // One-hot grant, zero whenever nothing is accepted.
  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[gidx] = 1'b1;
    end
  end

  // Route the granted requester's operands to the arithmetic unit.
  always_comb begin
    op_a   = req_a[gidx*N +: N];
    op_b   = req_b[gidx*N +: N];
    op_sub = req_sub[gidx];
  end

  smadd_core #(
    .N (N)
  ) u_core (
    .a   (op_a),
    .b   (op_b),
    .sub (op_sub),
    .sum (core_sum),
    .ovf (core_ovf)
  );

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Occupancy next state: fill on accept, drain on pop without refill, flush empties.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (accept) begin
          state_nxt = FULL;
        end else if (rsp_ready) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush) begin
      state_nxt = EMPTY;
    end
  end

  // Response payload: loaded on accept, held otherwise; flush only drops the overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_data <= '0;
      rsp_id   <= '0;
      rsp_ovf  <= 1'b0;
    end else if (flush) begin
      rsp_ovf  <= 1'b0;
    end else if (accept) begin
      rsp_data <= core_sum;
      rsp_id   <= gidx;
      rsp_ovf  <= core_ovf;
    end
  end

  // Round-robin pointer moves just past the last granted requester.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= gidx + IDW'(1);
    end
  end

  // Saturating count of accepted operations that overflowed.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_count <= '0;
    end else if (accept && core_ovf && (ovf_count != OVF_CNT_MAX)) begin
      ovf_count <= ovf_count + 8'd1;
    end
  end

endmodule

// File: doc/smadd_arbiter.md
SMADD_ARBITER -- requirements
Module: smadd_arbiter

Interface
REQ-001 Parameter N, default 32, total word width in sign-magnitude format (bit N-1 = sign, bits N-2:0 = magnitude).
REQ-002 Parameter Q, default 16, fraction bits; carried for documentation only, no effect on arithmetic.
REQ-003 Parameter NREQ, default 4, number of requesters; SHALL be a power of two, 2..8.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 flush  input  1  synchronous clear of the pending response; the round-robin pointer and counter are kept.
REQ-007 req_valid  input  NREQ  per-requester operation valid.
REQ-008 req_sub  input  NREQ  per-requester opcode: 0 = a+b, 1 = a-b.
REQ-009 req_a, req_b  input  NREQ*N  packed operands; requester i occupies bits [i*N +: N].
REQ-010 req_ready  output  NREQ  one-hot grant, combinational, asserted in the cycle the operation is accepted.
REQ-011 rsp_valid  output  1  result valid.
REQ-012 rsp_ready  input  1  consumer accepts the result.
REQ-013 rsp_data  output  N  sign-magnitude result.
REQ-014 rsp_id  output  log2(NREQ)  index of the requester that owns rsp_data.
REQ-015 rsp_ovf  output  1  overflow flag for rsp_data.
REQ-016 ovf_count  output  8  saturating count of overflowed results.

Function
REQ-017 Accept condition: any req_valid set, reset and flush both low, and (rsp_valid==0 or rsp_ready==1).
REQ-018 Grant: the lowest index i at or after pointer ptr, modulo NREQ, with req_valid[i]; req_ready SHALL be zero when no operation is accepted.
REQ-019 After a grant to i, ptr SHALL become (i+1) mod NREQ on the next edge; ptr is unchanged when there is no grant.
REQ-020 Latency: an operation accepted in cycle t SHALL appear on rsp_* at cycle t+1, registered.
REQ-021 Back-to-back operations SHALL be supported: a pop and a new accept in the same cycle give rsp_valid=1 continuously, with no bubble.
REQ-022 While rsp_valid=1 and rsp_ready=0, rsp_data, rsp_id and rsp_ovf SHALL hold stable.
REQ-023 Subtract: the sign of b SHALL be inverted before the add, so a-b is computed as a+(-b).
REQ-024 Same effective signs: magnitude = |a|+|b| over N-1 bits, and sign = the common sign.
REQ-025 Different signs: magnitude = larger minus smaller, and sign = the sign of the larger magnitude.
REQ-026 A zero magnitude result SHALL carry sign 0; negative zero is never produced.
REQ-027 Overflow: a carry out of magnitude bit N-2 SHALL set rsp_ovf=1, with magnitude saturated to all-ones and the common sign kept.
REQ-028 ovf_count SHALL increment on each accepted operation that overflows and SHALL stop at 255.
REQ-029 flush SHALL clear rsp_valid and rsp_ovf on the next edge and block accepts in that cycle; rsp_data and rsp_id keep their last values.
REQ-030 State machine with two states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-031 State transitions:
 - EMPTY->FULL on accept.
 - FULL->EMPTY on rsp_ready without accept.
 - FULL stays FULL on accept, or while rsp_ready=0.
 - Any state goes to EMPTY on flush.

Reset
REQ-032 When reset=1 at an edge, the following SHALL be zero: rsp_valid, rsp_data, rsp_id, rsp_ovf, ovf_count, ptr; state SHALL be EMPTY.
REQ-033 req_ready SHALL be zero for every cycle in which reset=1.
REQ-034 Reset SHALL take priority over flush and over accept.
REQ-035 Reset asserted with a result pending SHALL drop that result, and no rsp_valid pulse follows.

Structure
REQ-036 The shared package smadd_pkg SHALL hold N, Q, NREQ defaults, the state enum {EMPTY, FULL}, and the constant OVF_CNT_MAX=255.
REQ-037 The sign-magnitude arithmetic SHALL be one combinational sub-module, smadd_core, with ports a, b, sub, sum, ovf.
REQ-038 Arbitration, pointer, response register and counter SHALL live in smadd_arbiter.

Verification
REQ-039 Single add: req0 a=0x00010000 (+1.0), b=0x80030000 (-3.0), sub=0.
 - Required: req_ready=0001; next cycle rsp_valid=1, rsp_data=0x80020000, rsp_id=0, rsp_ovf=0.
REQ-040 Negative zero: req2 a=0x80008000, b=0x80008000, sub=1.
 - Required: rsp_data=0x00000000.
REQ-041 Overflow: req1 a=0x7FFFFFFF, b=0x00000001, sub=0.
 - Required: rsp_data=0x7FFFFFFF, rsp_ovf=1, ovf_count increments 0->1.
REQ-042 Round-robin: all four requesters hold req_valid, rsp_ready=1 throughout.
 - Required: grants 0,1,2,3,0 on consecutive cycles; rsp_valid high continuously from the second cycle.
REQ-043 Backpressure: rsp_ready=0 for 3 cycles with req0 and req1 valid.
 - Required: one grant only, rsp_* stable for 3 cycles, next grant in the cycle rsp_ready=1.
REQ-044 Mid-operation reset and flush: flush with rsp_valid=1, then reset while a result is pending.
 - Flush required: rsp_valid=0 next cycle, ptr kept.
 - Reset required: all outputs zero next cycle, ptr=0.
